// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone definitions: FSM states, widths and sizing helpers
package wb_pkg;

    // Command master sequencing: wait for a command, run the bus cycle, hold the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

    // Default bus geometry for blocks that do not override it
    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

    // Response status flags carried next to the data: err and timeout
    localparam int unsigned RSP_STATUS_W = 2;

    // One select line per byte lane
    function automatic int unsigned sel_width(input int unsigned dw);
        return (dw < 8) ? 1 : dw / 8;
    endfunction

    // Counter wide enough to hold the timeout limit; a disabled timeout still gets one bit
    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - saturating bus-cycle timer with an expiry flag
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = timer_width(TIMEOUT_CYCLES);
    // Expiry fires in the cycle the count shows limit-1, so the bus cycle lasts exactly the limit
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count idle bus cycles; hold at all-ones rather than wrapping back to a small value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // A zero limit disables the timeout entirely
    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - valid/ready command stream to single-beat Wishbone classic initiator
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [DW/8-1:0]   cmd_sel_i,
    input  logic [AW-1:0]     cmd_adr_i,
    input  logic [DW-1:0]     cmd_dat_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    localparam int unsigned SW = sel_width(DW);

    wbm_state_e     state_q, state_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  wdat_q, wdat_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_dat_q, rsp_dat_d;
    logic           rsp_err_q, rsp_err_d;
    logic           rsp_timeout_q, rsp_timeout_d;

    logic           timer_clear;
    logic           timer_en;
    logic           timer_expired;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State and every bus/response register; reset drops cyc immediately, even mid-cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            wdat_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            adr_q         <= adr_d;
            wdat_q        <= wdat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state decode; bus fields are only loaded on command acceptance so they stay put during BUS
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        sel_d         = sel_q;
        adr_d         = adr_q;
        wdat_d        = wdat_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d     = BUS;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    sel_d       = cmd_sel_i;
                    adr_d       = cmd_adr_i;
                    wdat_d      = cmd_dat_i;
                    timer_clear = 1'b1;
                end
            end

            BUS: begin
                timer_en = ~(wbm_ack_i | wbm_err_i);
                if (wbm_err_i) begin
                    // err outranks a simultaneous ack and never returns data
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else if (wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                end else if (timer_expired) begin
                    state_d       = RESP;
                    cyc_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_dat_d     = '0;
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = wdat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    localparam int M_ACK  = 0;
    localparam int M_NONE = 1;
    localparam int M_BOTH = 2;
    localparam int M_ERR  = 3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_ni = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [3:0]    cmd_sel_i = '0;
    logic [31:0]   cmd_adr_i = '0;
    logic [31:0]   cmd_dat_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   rsp_dat_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          busy_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_o;
    logic [31:0]   wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_cmd_master #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_sel_i     (cmd_sel_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_dat_i     (cmd_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_dat_i     (wbm_dat_i),
        .wbm_ack_i     (wbm_ack_i),
        .wbm_err_i     (wbm_err_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-model slave: terminates after s_wait wait states in the chosen mode
    logic [31:0] smem [16];
    logic [31:0] rmem [16];
    int          s_wait = 0;
    int          s_mode = M_ACK;
    int          s_cnt = 0;
    logic        stray = 1'b0;
    int          s_idx;

    always @(negedge wb_clk_i) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'hBAD0_BAD0;
        if (!wbm_cyc_o) begin
            s_cnt = 0;
            wbm_ack_i = stray;
        end else begin
            if (s_cnt == s_wait && s_mode != M_NONE) begin
                s_idx = int'(wbm_adr_o[5:2]);
                wbm_ack_i = (s_mode == M_ACK) || (s_mode == M_BOTH);
                wbm_err_i = (s_mode == M_ERR) || (s_mode == M_BOTH);
                wbm_dat_i = smem[s_idx];
                if (s_mode == M_ACK && wbm_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (wbm_sel_o[b]) smem[s_idx][8*b +: 8] = wbm_dat_o[8*b +: 8];
                end
            end
            s_cnt++;
        end
    end

    // Bus protocol monitor: stb tracks cyc, request fields hold while cyc is high, cyc run length
    int          cyc_run = 0;
    int          last_len = 0;
    logic        p_cyc = 1'b0;
    logic        p_we;
    logic [3:0]  p_sel;
    logic [31:0] p_adr, p_dat;

    always begin
        @(posedge wb_clk_i);
        #2;
        if (wb_rst_ni) begin
            check("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
            if (wbm_cyc_o) begin
                if (p_cyc) begin
                    check("hold_adr", wbm_adr_o, p_adr);
                    check("hold_dat", wbm_dat_o, p_dat);
                    check("hold_sel", wbm_sel_o, p_sel);
                    check("hold_we", wbm_we_o, p_we);
                end
                cyc_run++;
            end else if (p_cyc) begin
                last_len = cyc_run;
                cyc_run = 0;
            end
        end else begin
            cyc_run = 0;
        end
        p_cyc = wbm_cyc_o & wb_rst_ni;
        p_we  = wbm_we_o;
        p_sel = wbm_sel_o;
        p_adr = wbm_adr_o;
        p_dat = wbm_dat_o;
    end

    // One complete command/response exchange; sampling and driving happen at negedges
    task automatic run_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int wait_n, input int mode, input int rdelay,
                           output logic [31:0] r_dat, output logic r_err, output logic r_to,
                           output int lat, output int clen);
        int guard;
        r_dat = '0; r_err = 1'b0; r_to = 1'b0; lat = 0; clen = 0;
        s_wait = wait_n;
        s_mode = mode;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 20) begin
            @(negedge wb_clk_i);
            guard++;
        end
        check("cmd_accept", cmd_ready_o, 1'b1);
        if (cmd_ready_o !== 1'b1) begin
            cmd_valid_i = 1'b0;
            return;
        end
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        check("bus_cyc", wbm_cyc_o, 1'b1);
        check("bus_adr", wbm_adr_o, adr);
        check("bus_we", wbm_we_o, we);
        check("bus_sel", wbm_sel_o, sel);
        check("bus_dat", wbm_dat_o, dat);
        check("bus_ready_low", cmd_ready_o, 1'b0);
        check("bus_busy", busy_o, 1'b1);
        lat = 1;
        guard = 0;
        while (rsp_valid_o !== 1'b1 && guard < 40) begin
            @(negedge wb_clk_i);
            lat++;
            guard++;
        end
        check("rsp_valid_seen", rsp_valid_o, 1'b1);
        r_dat = rsp_dat_o;
        r_err = rsp_err_o;
        r_to  = rsp_timeout_o;
        clen  = last_len;
        for (int i = 0; i < rdelay; i++) begin
            @(negedge wb_clk_i);
            check("bp_valid", rsp_valid_o, 1'b1);
            check("bp_dat", rsp_dat_o, r_dat);
            check("bp_flags", {rsp_err_o, rsp_timeout_o}, {r_err, r_to});
            check("bp_cmd_ready", cmd_ready_o, 1'b0);
        end
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check("post_rsp_valid", rsp_valid_o, 1'b0);
        check("post_rsp_flags", {rsp_err_o, rsp_timeout_o}, 2'b00);
        check("post_rsp_ready", cmd_ready_o, 1'b1);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          wt;
        int          mode;
        int          rdly;
        logic [31:0] e_dat;
        logic        e_err;
        logic        e_to;
        int          e_len;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] g_dat;
    logic        g_err, g_to;
    int          g_lat, g_len;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 0, M_ACK,  0, 32'h0000_0000, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 4'hF, 32'h3000_0008, 32'h0000_0000, 3, M_ACK,  1, 32'h1234_5678, 1'b0, 1'b0, 4};
        tbl[2]  = '{1'b0, 4'hF, 32'h3000_0004, 32'h0000_0000, 1, M_ACK,  0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b1, 4'h5, 32'h3000_0010, 32'hAABB_CCDD, 2, M_ACK,  2, 32'h0000_0000, 1'b0, 1'b0, 3};
        tbl[4]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0000_0000, 0, M_ACK,  0, 32'h04BB_04DD, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b1, 4'hF, 32'h3000_000C, 32'h1111_1111, 0, M_NONE, 0, 32'h0000_0000, 1'b0, 1'b1, TO};
        tbl[6]  = '{1'b0, 4'hF, 32'h3000_0008, 32'h0000_0000, 1, M_BOTH, 0, 32'h0000_0000, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b1, 4'hF, 32'h3000_000C, 32'hFFFF_FFFF, 0, M_ERR,  0, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[8]  = '{1'b0, 4'hF, 32'h3000_000C, 32'h0000_0000, 2, M_ACK,  0, 32'h0303_0303, 1'b0, 1'b0, 3};
        tbl[9]  = '{1'b1, 4'h0, 32'h3000_0014, 32'h1234_5678, 0, M_ACK,  0, 32'h0000_0000, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b0, 4'hF, 32'h3000_0014, 32'h0000_0000, 0, M_ACK,  0, 32'h0505_0505, 1'b0, 1'b0, 1};
        tbl[11] = '{1'b0, 4'h3, 32'h3000_0000, 32'h0000_0000, 0, M_NONE, 3, 32'h0000_0000, 1'b0, 1'b1, TO};
        tbl[12] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0000_0000, 4, M_ERR,  0, 32'h0000_0000, 1'b1, 1'b0, 5};

        for (int i = 0; i < 16; i++) smem[i] = 32'h0101_0101 * i;
        smem[2] = 32'h1234_5678;

        // Reset state
        #12;
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_dat", rsp_dat_o, 32'h0);
        check("rst_flags", {rsp_err_o, rsp_timeout_o, busy_o}, 3'b000);
        check("rst_bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o | wbm_dat_o}, 37'h0);
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_cmd(tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, tbl[i].wt, tbl[i].mode, tbl[i].rdly,
                    g_dat, g_err, g_to, g_lat, g_len);
            check($sformatf("tbl%0d_dat", i), g_dat, tbl[i].e_dat);
            check($sformatf("tbl%0d_err", i), g_err, tbl[i].e_err);
            check($sformatf("tbl%0d_timeout", i), g_to, tbl[i].e_to);
            check($sformatf("tbl%0d_cyc_len", i), g_len, tbl[i].e_len);
            check($sformatf("tbl%0d_latency", i), g_lat, tbl[i].e_len + 1);
        end

        // Back-pressure with the next command already waiting
        s_mode = M_ACK;
        s_wait = 0;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i = 1'b0; cmd_sel_i = 4'hF; cmd_adr_i = 32'h3000_0004; cmd_dat_i = '0;
        check("bp_idle_ready", cmd_ready_o, 1'b1);
        @(negedge wb_clk_i);
        check("bp_cyc", wbm_cyc_o, 1'b1);
        @(negedge wb_clk_i);
        check("bp_first_rsp", rsp_valid_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_ready", cmd_ready_o, 1'b0);
            check("bp_hold_valid", rsp_valid_o, 1'b1);
            check("bp_hold_dat", rsp_dat_o, 32'hDEAD_BEEF);
            check("bp_hold_cyc", wbm_cyc_o, 1'b0);
            @(negedge wb_clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check("bp_after_valid", rsp_valid_o, 1'b0);
        check("bp_after_ready", cmd_ready_o, 1'b1);
        check("bp_after_cyc", wbm_cyc_o, 1'b0);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        check("bp_second_cyc", wbm_cyc_o, 1'b1);
        check("bp_second_ready", cmd_ready_o, 1'b0);
        @(negedge wb_clk_i);
        check("bp_second_rsp", rsp_valid_o, 1'b1);
        check("bp_second_dat", rsp_dat_o, 32'hDEAD_BEEF);
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;

        // Reset in the middle of a bus cycle, then a stray ack
        s_mode = M_NONE;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i = 1'b1; cmd_sel_i = 4'hF; cmd_adr_i = 32'h3000_0020; cmd_dat_i = 32'h5555_AAAA;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        @(negedge wb_clk_i);
        check("mid_cyc_before", wbm_cyc_o, 1'b1);
        #2 wb_rst_ni = 1'b0;
        #1;
        check("mid_rst_cyc", wbm_cyc_o, 1'b0);
        check("mid_rst_stb", wbm_stb_o, 1'b0);
        check("mid_rst_valid", rsp_valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ready", cmd_ready_o, 1'b1);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i);
        #1 stray = 1'b1;
        @(posedge wb_clk_i);
        #1 stray = 1'b0;
        @(negedge wb_clk_i);
        check("stray_cyc", wbm_cyc_o, 1'b0);
        check("stray_valid", rsp_valid_o, 1'b0);
        check("stray_flags", {rsp_err_o, rsp_timeout_o, busy_o}, 3'b000);
        check("stray_ready", cmd_ready_o, 1'b1);

        // Randomised traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        for (int n = 0; n < 1000; n++) begin
            logic        we;
            logic [3:0]  sel;
            logic [31:0] dat, mask, e_dat;
            logic        e_err, e_to;
            int          widx, wt, r, mode, rd, e_len;
            we   = 1'($urandom_range(0, 1));
            sel  = 4'($urandom);
            widx = $urandom_range(0, 15);
            dat  = $urandom;
            wt   = $urandom_range(0, 5);
            r    = $urandom_range(0, 99);
            mode = (r < 80) ? M_ACK : (r < 88) ? M_ERR : (r < 94) ? M_BOTH : M_NONE;
            rd   = $urandom_range(0, 3);
            e_dat = '0; e_err = 1'b0; e_to = 1'b0; e_len = wt + 1;
            if (mode == M_NONE) begin
                e_to = 1'b1;
                e_len = TO;
            end else if (mode != M_ACK) begin
                e_err = 1'b1;
            end else if (we) begin
                mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                rmem[widx] = (rmem[widx] & ~mask) | (dat & mask);
            end else begin
                e_dat = rmem[widx];
            end
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
            run_cmd(we, sel, 32'h3000_0000 + 32'(widx * 4), dat, wt, mode, rd,
                    g_dat, g_err, g_to, g_lat, g_len);
            check("rnd_dat", g_dat, e_dat);
            check("rnd_status", {g_err, g_to}, {e_err, e_to});
            check("rnd_cyc_len", g_len, e_len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
